// File: rtl/text_row_formatter.sv
// text_row_formatter: 16-column character row. Columns 0-9 are a free label
// written through the label port; columns 10-15 show a 16-bit value as
// right-aligned unsigned decimal or "0x" hex, produced by a convert/write FSM.
module text_row_formatter #(
    parameter logic [7:0] ADDRESS_OFFSET = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        mode,
    input  logic        valueValid,
    output logic        ready,
    output logic        done,
    input  logic        wrEn,
    input  logic [3:0]  wrCol,
    input  logic [7:0]  wrChar,
    input  logic [7:0]  readAddress,
    output logic [7:0]  outByte
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic        mode_q, mode_d;
    logic [3:0]  iter_q, iter_d;
    logic [3:0]  col_q, col_d;
    logic        done_q, done_d;
    logic [7:0]  buf_q [16];
    logic [19:0] bcd_adj;
    logic [7:0]  wr_char;

    // ASCII for one nibble: '0'-'9', then uppercase 'A'-'F'
    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Double-dabble correction for one BCD digit
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // BCD digits corrected before each shift
    always_comb begin
        bcd_adj = {dabble(bcd_q[19:16]), dabble(bcd_q[15:12]), dabble(bcd_q[11:8]),
                   dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
    end

    // Next-state logic for the accept / convert / write sequence
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        mode_d  = mode_q;
        iter_d  = iter_q;
        col_d   = col_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valueValid) begin
                    bin_d   = value;
                    mode_d  = mode;
                    bcd_d   = '0;
                    iter_d  = '0;
                    col_d   = 4'd10;
                    state_d = mode ? S_CONVERT : S_WRITE;
                end
            end
            S_CONVERT: begin
                bcd_d  = {bcd_adj[18:0], bin_q[15]};
                bin_d  = {bin_q[14:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = S_WRITE;
                    col_d   = 4'd10;
                end
            end
            S_WRITE: begin
                col_d = col_q + 4'd1;
                if (col_q == 4'd15) begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Character for the value column currently being written; leading
    // decimal zeros blank out until the first non-zero digit (d0 always shown)
    always_comb begin
        logic z4, z3, z2, z1;
        z4 = (bcd_q[19:16] == 4'd0);
        z3 = z4 && (bcd_q[15:12] == 4'd0);
        z2 = z3 && (bcd_q[11:8] == 4'd0);
        z1 = z2 && (bcd_q[7:4] == 4'd0);
        wr_char = 8'h20;
        case (col_q)
            4'd10: wr_char = mode_q ? 8'h20 : 8'h30;
            4'd11: wr_char = mode_q ? (z4 ? 8'h20 : nib_ascii(bcd_q[19:16])) : 8'h78;
            4'd12: wr_char = mode_q ? (z3 ? 8'h20 : nib_ascii(bcd_q[15:12])) : nib_ascii(bin_q[15:12]);
            4'd13: wr_char = mode_q ? (z2 ? 8'h20 : nib_ascii(bcd_q[11:8])) : nib_ascii(bin_q[11:8]);
            4'd14: wr_char = mode_q ? (z1 ? 8'h20 : nib_ascii(bcd_q[7:4])) : nib_ascii(bin_q[7:4]);
            4'd15: wr_char = mode_q ? nib_ascii(bcd_q[3:0]) : nib_ascii(bin_q[3:0]);
            default: wr_char = 8'h20;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            mode_q  <= 1'b0;
            iter_q  <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            mode_q  <= mode_d;
            iter_q  <= iter_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    // Character storage: label port owns cols 0-9, FSM owns cols 10-15
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                buf_q[i[3:0]] <= 8'h20;
            end
        end else begin
            if (wrEn && (wrCol <= 4'd9)) begin
                buf_q[wrCol] <= wrChar;
            end
            if (state_q == S_WRITE) begin
                buf_q[col_q] <= wr_char;
            end
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = done_q;
    assign outByte = (readAddress[7:4] == ADDRESS_OFFSET[7:4]) ? buf_q[readAddress[3:0]] : 8'h00;

endmodule

// File: tb/tb_text_row_formatter.sv
// Randomized self-checking bench for text_row_formatter (row at address 16).
module tb_text_row_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        mode;
    logic        valueValid;
    logic        ready;
    logic        done;
    logic        wrEn;
    logic [3:0]  wrCol;
    logic [7:0]  wrChar;
    logic [7:0]  readAddress;
    logic [7:0]  outByte;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model [16];

    text_row_formatter #(.ADDRESS_OFFSET(8'd16)) dut (
        .clk(clk), .reset(reset), .value(value), .mode(mode),
        .valueValid(valueValid), .ready(ready), .done(done),
        .wrEn(wrEn), .wrCol(wrCol), .wrChar(wrChar),
        .readAddress(readAddress), .outByte(outByte)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference text for a value column, derived from the printed-number rules
    function automatic logic [7:0] fmt_char(input int col, input logic [15:0] v, input logic m);
        int p, pow, dig, nib;
        if (m) begin
            if (col == 10) return 8'h20;
            p = 15 - col;
            pow = 1;
            for (int k = 0; k < p; k++) pow = pow * 10;
            if (p != 0 && int'(v) < pow) return 8'h20;
            dig = (int'(v) / pow) % 10;
            return 8'(8'h30 + dig);
        end else begin
            if (col == 10) return 8'h30;
            if (col == 11) return 8'h78;
            nib = (int'(v) >> (4 * (15 - col))) & 15;
            return (nib < 10) ? 8'(8'h30 + nib) : 8'(8'h41 + nib - 10);
        end
    endfunction

    task automatic read_row(input string tag);
        for (int i = 0; i < 16; i++) begin
            readAddress = 8'(16 + i);
            #1;
            check($sformatf("%s[%0d]", tag, i), outByte, model[i]);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_conv(input logic [15:0] v, input logic m, input bit junk, input bit label);
        int lat, done_at, done_cnt, busy_ready;
        string lbl;
        lbl = "Temp:";
        lat = m ? 22 : 6;
        done_at = 0; done_cnt = 0; busy_ready = 0;
        value = v; mode = m; valueValid = 1'b1;
        @(posedge clk); #1;                       // E0 accept
        valueValid = junk;
        if (junk) begin value = 16'h1111; mode = ~m; end
        for (int k = 1; k <= lat + 2; k++) begin
            @(posedge clk); #1;
            wrEn = 1'b0;
            if (k < lat && ready) busy_ready++;
            if (k == lat) check("ready_after_write", ready, 1);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            valueValid = junk && (k < lat);
            if (label && k <= 5) begin
                wrEn = 1'b1; wrCol = 4'(k - 1); wrChar = lbl[k-1];
                model[k-1] = lbl[k-1];
            end
            if (label && k == lat - 2) begin     // after col 12 was written
                wrEn = 1'b1; wrCol = 4'd12; wrChar = 8'h5A;
            end
        end
        wrEn = 1'b0; valueValid = 1'b0;
        check("ready_low_busy", busy_ready, 0);
        check("done_latency", done_at, lat);
        check("done_count", done_cnt, 1);
        for (int c = 10; c < 16; c++) model[c] = fmt_char(c, v, m);
        read_row(m ? "dec" : "hex");
    endtask

    initial begin
        int dcnt;
        logic [15:0] rv;
        logic [3:0]  rc;
        logic [7:0]  rch;
        reset = 1'b1; value = '0; mode = 1'b0; valueValid = 1'b0;
        wrEn = 1'b0; wrCol = '0; wrChar = '0; readAddress = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h20;
        read_row("reset_row");
        readAddress = 8'd0;  #1; check("other_row_0", outByte, 0);
        readAddress = 8'd32; #1; check("other_row_32", outByte, 0);
        readAddress = 8'hFF; #1; check("other_row_ff", outByte, 0);
        @(posedge clk); #1;

        run_conv(16'd1234, 1'b1, 1'b0, 1'b0);
        run_conv(16'd0, 1'b1, 1'b0, 1'b0);
        run_conv(16'd65535, 1'b1, 1'b0, 1'b0);
        run_conv(16'hBEEF, 1'b0, 1'b0, 1'b0);
        run_conv(16'hBEEF, 1'b0, 1'b1, 1'b0);
        run_conv(16'd907, 1'b1, 1'b1, 1'b1);

        // label write visible one edge later; out-of-range column ignored
        wrEn = 1'b1; wrCol = 4'd7; wrChar = 8'h41;
        @(posedge clk); #1;
        wrEn = 1'b0; readAddress = 8'd23; #1;
        check("label_one_edge", outByte, 8'h41);
        model[7] = 8'h41;
        wrEn = 1'b1; wrCol = 4'd13; wrChar = 8'h51;
        @(posedge clk); #1;
        wrEn = 1'b0;
        read_row("label_ignore");

        // reset in the middle of a decimal conversion
        value = 16'd5555; mode = 1'b1; valueValid = 1'b1;
        @(posedge clk); #1;
        valueValid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        for (int i = 0; i < 16; i++) model[i] = 8'h20;
        read_row("abort_row");
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        run_conv(16'd42, 1'b1, 1'b0, 1'b0);

        // randomized mix of label writes and conversions
        for (int n = 0; n < 20; n++) begin
            rc = 4'($urandom_range(0, 15));
            rch = 8'($urandom_range(33, 126));
            wrEn = 1'b1; wrCol = rc; wrChar = rch;
            @(posedge clk); #1;
            wrEn = 1'b0;
            if (rc <= 4'd9) model[rc] = rch;
            case ($urandom_range(0, 3))
                0: rv = 16'($urandom_range(0, 9));
                1: rv = 16'($urandom_range(9990, 10010));
                default: rv = 16'($urandom);
            endcase
            run_conv(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
